// File: rtl/input_debounce.sv
// Switch/button conditioner: synchronises each raw input, rejects contact bounce
// with a per-channel stability counter, and emits clean levels plus edge strobes.
module input_debounce #(
    parameter int WIDTH       = 2,
    parameter int CNT_MAX     = 250000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int               CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    // Plain flop chain: nothing may sit between stages or metastability leaks through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic             clean_q;
        logic             rise_q;
        logic             fall_q;
        logic             clean_nxt;
        logic             rise_nxt;
        logic             fall_nxt;
        logic             differ;
        logic             expired;
        logic             accept;

        assign differ  = s[ch] != clean_q;
        assign expired = cnt == CNT_LAST;
        assign accept  = (state == PENDING) && differ && expired;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= STABLE;
                cnt     <= '0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                clean_q <= clean_nxt;
                rise_q  <= rise_nxt;
                fall_q  <= fall_nxt;
            end
        end

        // Any return to the clean level while pending discards the partial count.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = '0;
            case (state)
                STABLE: begin
                    if (differ) begin
                        state_nxt = PENDING;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                PENDING: begin
                    if (!differ || expired) begin
                        state_nxt = STABLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            endcase
        end

        always_comb begin
            clean_nxt = clean_q;
            rise_nxt  = 1'b0;
            fall_nxt  = 1'b0;
            if (accept) begin
                clean_nxt = s[ch];
                rise_nxt  = s[ch];
                fall_nxt  = !s[ch];
            end
        end

        assign clean[ch] = clean_q;
        assign rise[ch]  = rise_q;
        assign fall[ch]  = fall_q;
    end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with a short stability window (CNT_MAX=4).
module tb_input_debounce;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] raw   = 2'b11;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;

    int errors    = 0;
    int checks    = 0;
    int rise_cnt0 = 0;

    logic bounce [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    input_debounce #(
        .WIDTH       (2),
        .CNT_MAX     (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw),
        .clean (clean),
        .rise  (rise),
        .fall  (fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One rising edge, then sample 1 time unit later; inputs change right after.
    task automatic step();
        @(posedge clk);
        #1;
        if (rise[0]) rise_cnt0++;
    endtask

    initial begin
        // Asynchronous reset, checked before the first clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("reset_clean", 32'(clean), 32'(2'b00));
        chk("reset_rise",  32'(rise),  32'(2'b00));
        chk("reset_fall",  32'(fall),  32'(2'b00));
        step();
        step();
        chk("reset_hold_clean", 32'(clean), 32'(2'b00));
        raw   = 2'b00;
        rst_n = 1'b1;
        repeat (4) step();
        chk("idle_clean", 32'(clean), 32'(2'b00));

        // Clean press on channel 0
        raw = 2'b01;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("press_fall", 32'(fall), 32'(2'b00));
            if (e < 6) chk("press_rise_early", 32'(rise), 32'(2'b00));
            if (e == 5) chk("press_clean_e5", 32'(clean), 32'(2'b00));
            if (e == 6) begin
                chk("press_clean_e6", 32'(clean), 32'(2'b01));
                chk("press_rise_e6",  32'(rise),  32'(2'b01));
            end
            if (e == 7) begin
                chk("press_rise_e7",  32'(rise),  32'(2'b00));
                chk("press_clean_e7", 32'(clean), 32'(2'b01));
            end
        end

        // Release channel 0
        raw = 2'b00;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk("rel0_rise", 32'(rise), 32'(2'b00));
            if (e < 6) begin
                chk("rel0_fall_early",  32'(fall),  32'(2'b00));
                chk("rel0_clean_early", 32'(clean), 32'(2'b01));
            end
            if (e == 6) begin
                chk("rel0_fall_e6",  32'(fall),  32'(2'b01));
                chk("rel0_clean_e6", 32'(clean), 32'(2'b00));
            end
            if (e == 7) chk("rel0_fall_e7", 32'(fall), 32'(2'b00));
        end

        // Bounce on channel 0: 2-cycle pulses must be rejected
        rise_cnt0 = 0;
        for (int i = 0; i < 8; i++) begin
            raw[0] = bounce[i];
            step();
            chk("bounce_clean", 32'(clean), 32'(2'b00));
        end
        raw[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("bounce_fall", 32'(fall), 32'(2'b00));
            if (e < 6) chk("bounce_hold_clean", 32'(clean), 32'(2'b00));
            if (e == 6) begin
                chk("bounce_clean_e6", 32'(clean), 32'(2'b01));
                chk("bounce_rise_e6",  32'(rise),  32'(2'b01));
            end
            if (e > 6) chk("bounce_rise_late", 32'(rise), 32'(2'b00));
        end
        chk("bounce_rise_count", 32'(rise_cnt0), 32'd1);

        // Back to idle, then simultaneous press on both channels
        raw = 2'b00;
        repeat (8) step();
        chk("idle2_clean", 32'(clean), 32'(2'b00));
        raw = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) chk("simul_clean_e5", 32'(clean), 32'(2'b00));
            if (e == 6) begin
                chk("simul_clean_e6", 32'(clean), 32'(2'b11));
                chk("simul_rise_e6",  32'(rise),  32'(2'b11));
                chk("simul_fall_e6",  32'(fall),  32'(2'b00));
            end
            if (e == 7) begin
                chk("simul_rise_e7",  32'(rise),  32'(2'b00));
                chk("simul_clean_e7", 32'(clean), 32'(2'b11));
            end
        end

        // Release channel 1 while channel 0 stays high
        raw = 2'b01;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6) chk("rel1_fall_early", 32'(fall), 32'(2'b00));
            if (e == 6) begin
                chk("rel1_fall_e6",  32'(fall),  32'(2'b10));
                chk("rel1_clean_e6", 32'(clean), 32'(2'b01));
                chk("rel1_rise_e6",  32'(rise),  32'(2'b00));
            end
            if (e == 7) begin
                chk("rel1_fall_e7",  32'(fall),  32'(2'b00));
                chk("rel1_clean_e7", 32'(clean), 32'(2'b01));
            end
        end

        // Reset in the middle of a count on channel 0
        raw = 2'b00;
        repeat (8) step();
        chk("idle3_clean", 32'(clean), 32'(2'b00));
        raw = 2'b01;
        repeat (3) step();
        chk("mid_clean_pre", 32'(clean), 32'(2'b00));
        rst_n = 1'b0;
        #1;
        chk("mid_reset_clean", 32'(clean), 32'(2'b00));
        chk("mid_reset_rise",  32'(rise),  32'(2'b00));
        repeat (3) step();
        chk("mid_reset_hold_clean", 32'(clean), 32'(2'b00));
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e < 6) begin
                chk("mid_post_clean_early", 32'(clean), 32'(2'b00));
                chk("mid_post_rise_early",  32'(rise),  32'(2'b00));
            end
            if (e == 6) begin
                chk("mid_post_clean_e6", 32'(clean), 32'(2'b01));
                chk("mid_post_rise_e6",  32'(rise),  32'(2'b01));
            end
            if (e == 7) chk("mid_post_rise_e7", 32'(rise), 32'(2'b00));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
